// File: rtl/dl_buf_pkg.sv
// Shared types and constants for the download write buffer.
// The optional byte-pair merge feature is controlled by DL_WRITE_BUFFER_MERGE_EN.
package dl_buf_pkg;

    // Default byte-address width of the download stream.
    localparam int DL_AW = 25;

    // Handshake FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dl_state_t;

    // One captured download byte.
    typedef struct packed {
        logic [DL_AW-1:0] addr;
        logic [7:0]       data;
    } dl_entry_t;

    // Byte-enable patterns on the 16-bit write port.
    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_W  = 2'b11;

    // Select the byte lane from the low address bit.
    function automatic logic [1:0] lane_be(input logic addr0);
        return addr0 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO with head and head+1 read ports and a 0/1/2 pop count.
// Full/empty are derived from the occupancy counter, not pointer equality.
// Used by dl_write_buffer; DL_WRITE_BUFFER_MERGE_EN there decides whether
// the head+1 port is consumed.
module dl_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [1:0]                 pop_cnt,
    output logic                       accepted,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           head_next,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;

    // A push is taken when there is room, or when a pop frees room this cycle.
    assign accepted  = push && ((level_reg != LW'(DEPTH)) || (pop_cnt != 2'd0));
    assign head      = mem[rd_ptr_reg];
    assign head_next = mem[rd_ptr_reg + PW'(1)];
    assign level     = level_reg;

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (accepted) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            rd_ptr_reg <= rd_ptr_reg + PW'(pop_cnt);
            level_reg  <= level_reg + LW'(accepted) - LW'(pop_cnt);
        end
    end

endmodule

// File: rtl/dl_write_buffer.sv
// Download write buffer: captures byte strobes from the download receiver
// into a FIFO and replays them to the 16-bit SDRAM write port via req/ack.
// Define DL_WRITE_BUFFER_MERGE_EN to combine an aligned even/odd byte pair
// at the head of the FIFO into one full-word write.
import dl_buf_pkg::*;

module dl_write_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = DL_AW
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dl_wr,
    input  logic [AW-1:0]          dl_addr,
    input  logic [7:0]             dl_data,
    input  logic                   dl_active,
    output logic                   mem_req,
    output logic [AW-2:0]          mem_addr,
    output logic [15:0]            mem_din,
    output logic [1:0]             mem_be,
    input  logic                   mem_ack,
    output logic                   cpu_hold,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = AW + 8;

    dl_state_t     state_reg;
    dl_state_t     state_next;
    logic          load;
    logic [1:0]    pop_cnt;
    logic          accepted;
    logic [EW-1:0] head;
    logic [EW-1:0] head_next;
    logic [AW-1:0] head_addr;
    logic [7:0]    head_data;
    logic          merge_ok;
    logic          merged_reg;
    logic          active_d_reg;

    assign head_addr = head[EW-1:8];
    assign head_data = head[7:0];

    dl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (dl_wr),
        .wr_data   ({dl_addr, dl_data}),
        .pop_cnt   (pop_cnt),
        .accepted  (accepted),
        .head      (head),
        .head_next (head_next),
        .level     (level)
    );

`ifdef DL_WRITE_BUFFER_MERGE_EN
    logic [AW-1:0] next_addr;
    assign next_addr = head_next[EW-1:8];
    // Merge an even-addressed head with its odd neighbour sitting right behind it.
    assign merge_ok  = (level >= LW'(2)) && !head_addr[0] &&
                       (next_addr == head_addr + AW'(1));
`else
    logic [EW-1:0] unused_head_next;
    assign unused_head_next = head_next;
    assign merge_ok         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, request load and pop count.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        pop_cnt    = 2'd0;
        case (state_reg)
            IDLE: begin
                if (level != '0) begin
                    load       = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    pop_cnt    = merged_reg ? 2'd2 : 2'd1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request outputs: loaded from the head in IDLE, held stable through WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_be     <= '0;
            merged_reg <= 1'b0;
        end else if (load) begin
            mem_req  <= 1'b1;
            mem_addr <= head_addr[AW-1:1];
            if (merge_ok) begin
                mem_din    <= {head_next[7:0], head_data};
                mem_be     <= BE_W;
                merged_reg <= 1'b1;
            end else begin
                mem_din    <= {head_data, head_data};
                mem_be     <= lane_be(head_addr[0]);
                merged_reg <= 1'b0;
            end
        end else if (state_reg == WAIT && mem_ack) begin
            mem_req <= 1'b0;
        end
    end

    // Sticky drop flag, cleared on a new download; CPU hold while anything is pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_d_reg <= 1'b0;
            overflow     <= 1'b0;
            cpu_hold     <= 1'b0;
        end else begin
            active_d_reg <= dl_active;
            if (dl_wr && !accepted) begin
                overflow <= 1'b1;
            end else if (dl_active && !active_d_reg) begin
                overflow <= 1'b0;
            end
            cpu_hold <= dl_active || (level != '0) || (state_reg != IDLE);
        end
    end

endmodule

// File: tb/tb_dl_write_buffer.sv
// Directed self-checking bench for dl_write_buffer (DEPTH=8, AW=25).
// Expectations for the pair tests follow DL_WRITE_BUFFER_MERGE_EN.
module tb_dl_write_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 25;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_active;
    logic          mem_req;
    logic [AW-2:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_be;
    logic          mem_ack;
    logic          cpu_hold;
    logic          overflow;
    logic [3:0]    level;

    int errors = 0;
    int checks = 0;

    dl_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_active (dl_active),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .cpu_hold  (cpu_hold),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic [23:0] a, input logic [15:0] d,
                           input logic [1:0] be);
        wait_req({tag, "_req"});
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_din"}, 32'(mem_din), 32'(d));
        chk({tag, "_be"}, 32'(mem_be), 32'(be));
    endtask

    initial begin
        logic [7:0] d;
        int idx;
        reset_n   = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        dl_active = 1'b0;
        mem_ack   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", 32'(mem_din), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single byte at odd address, one-stage latency, ack two cycles after req
        push(25'h000005, 8'hA7);
        chk("s_level1", 32'(level), 32'd1);
        chk("s_noreq", 32'(mem_req), 32'd0);
        tick();
        chk("s_lat_req", 32'(mem_req), 32'd1);
        chk("s_addr", 32'(mem_addr), 32'h000002);
        chk("s_din", 32'(mem_din), 32'hA7A7);
        chk("s_be", 32'(mem_be), 32'h2);
        chk("s_hold", 32'(cpu_hold), 32'd1);
        tick();
        chk("s_held_req", 32'(mem_req), 32'd1);
        ack();
        chk("s_req_drop", 32'(mem_req), 32'd0);
        chk("s_level0", 32'(level), 32'd0);
        chk("s_hold_ack", 32'(cpu_hold), 32'd1);
        tick();
        chk("s_hold_fall", 32'(cpu_hold), 32'd0);
        // Stray ack in IDLE changes nothing
        ack();
        tick();
        chk("idle_ack_req", 32'(mem_req), 32'd0);
        chk("idle_ack_lvl", 32'(level), 32'd0);

        // Burst of DEPTH+2 odd-address bytes with ack withheld
        dl_active = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(25'h001001 + 25'(2 * i), 8'(8'h10 + i));
        end
        chk("b_level", 32'(level), 32'(DEPTH));
        chk("b_ovf", 32'(overflow), 32'd1);
        chk("b_hold", 32'(cpu_hold), 32'd1);
        chk_req("b_first", 24'h000800, 16'h1010, 2'b10);
        // New download clears the overflow flag
        dl_active = 1'b0;
        tick();
        chk("b_ovf_keep", 32'(overflow), 32'd1);
        dl_active = 1'b1;
        tick();
        chk("b_ovf_clr", 32'(overflow), 32'd0);
        chk("b_level_hold", 32'(level), 32'(DEPTH));

        // Push and pop in the same cycle while full
        dl_wr   = 1'b1;
        dl_addr = 25'h001015;
        dl_data = 8'h1A;
        mem_ack = 1'b1;
        tick();
        dl_wr   = 1'b0;
        mem_ack = 1'b0;
        chk("pp_level", 32'(level), 32'(DEPTH));
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_req", 32'(mem_req), 32'd0);

        // Drain remaining DEPTH entries in order
        dl_active = 1'b0;
        for (int j = 1; j <= DEPTH; j++) begin
            idx = (j < DEPTH) ? j : 10;
            d = 8'(8'h10 + idx);
            chk_req($sformatf("drain%0d", j), 24'(24'h000800 + idx), {d, d}, 2'b10);
            ack();
        end
        chk("drain_level", 32'(level), 32'd0);
        tick();
        tick();
        chk("drain_noreq", 32'(mem_req), 32'd0);
        chk("drain_hold", 32'(cpu_hold), 32'd0);

        // Asynchronous reset while in WAIT
        push(25'h000020, 8'h55);
        wait_req("r_req");
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_async_req", 32'(mem_req), 32'd0);
        chk("r_async_lvl", 32'(level), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        ack();
        tick();
        tick();
        chk("r_noreq", 32'(mem_req), 32'd0);
        chk("r_level", 32'(level), 32'd0);

        // Aligned pair queued behind a pending write
        push(25'h000001, 8'h99);
        push(25'h000100, 8'h11);
        push(25'h000101, 8'h22);
        chk_req("m_dummy", 24'h000000, 16'h9999, 2'b10);
        ack();
        chk("m_level2", 32'(level), 32'd2);
`ifdef DL_WRITE_BUFFER_MERGE_EN
        chk_req("m_word", 24'h000080, 16'h2211, 2'b11);
        ack();
        chk("m_level0", 32'(level), 32'd0);
`else
        chk_req("m_lo", 24'h000080, 16'h1111, 2'b01);
        ack();
        chk("m_level1", 32'(level), 32'd1);
        chk_req("m_hi", 24'h000080, 16'h2222, 2'b10);
        ack();
        chk("m_level0", 32'(level), 32'd0);
`endif

        // Unaligned pair never merges
        push(25'h000001, 8'h99);
        push(25'h000101, 8'h33);
        push(25'h000102, 8'h44);
        chk_req("u_dummy", 24'h000000, 16'h9999, 2'b10);
        ack();
        chk_req("u_first", 24'h000080, 16'h3333, 2'b10);
        ack();
        chk("u_level1", 32'(level), 32'd1);
        chk_req("u_second", 24'h000081, 16'h4444, 2'b01);
        ack();
        chk("u_level0", 32'(level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dl_write_buffer.md
Name: dl_write_buffer

Overview:
- Sits directly downstream of the file-download SPI receiver. It captures that receiver's one-clock byte-write strobes (wr, 25-bit address, 8-bit data) into a small FIFO.
- It replays the captured writes to the 16-bit SDRAM write port using a req/ack handshake with byte enables.
- It decouples the SPI-rate byte stream from SDRAM arbitration latency and holds the CPU off memory while a download or its drain is in progress.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- AW, 25, byte-address width of the download stream.

Ports:
- clk  in  1  system clock; same clock as the download receiver's write side.
- reset_n  in  1  asynchronous active-low reset.
- dl_wr  in  1  single-cycle byte write strobe from the download receiver.
- dl_addr  in  AW  byte address qualified by dl_wr.
- dl_data  in  8  byte data qualified by dl_wr.
- dl_active  in  1  download-in-progress level from the download receiver.
- mem_req  out  1  write request to the SDRAM controller.
- mem_addr  out  AW-1  word address, equal to byte address bits [AW-1:1].
- mem_din  out  16  write data.
- mem_be  out  2  byte enables; bit0 = low byte (even address), bit1 = high byte.
- mem_ack  in  1  one-cycle completion pulse from the SDRAM controller.
- cpu_hold  out  1  holds CPU bus access off.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FIFO is emptied; state is IDLE.
  - mem_req=0, mem_addr=0, mem_din=0, mem_be=0, overflow=0, level=0.
  - cpu_hold=0 until dl_active is seen.
- Reset mid-transaction abandons the outstanding request. No retry is made after reset.
- Push:
  - dl_wr=1 writes {dl_addr, dl_data} into the FIFO on that edge if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- Overflow clears only on reset or on a rising edge of dl_active.
- Pop occurs on the cycle mem_ack is accepted in state WAIT.
- Simultaneous push and pop leaves level unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from level, never from pointer equality alone.
- State machine:
  - IDLE: if FIFO not empty, load the output registers from the head entry, set mem_req=1, go to WAIT.
  - WAIT: hold mem_req, mem_addr, mem_din and mem_be stable until mem_ack=1. On ack: pop, drop mem_req, and return to IDLE.
  - Back-to-back transfers therefore carry one idle cycle between requests.
  - mem_ack in IDLE is ignored.
- Lane mapping: mem_din={d,d}; mem_be=2'b01 if addr[0]=0, else 2'b10.
- Latency: dl_wr at edge N, FIFO empty, state IDLE gives mem_req=1 after edge N+1 (one register stage). Minimum cost per byte is 3 cycles including the ack.
- cpu_hold = dl_active OR level!=0 OR state!=IDLE, registered. It deasserts one cycle after the last ack once dl_active is low.

Optional Feature:
- Macro: DL_WRITE_BUFFER_MERGE_EN.
- Enabled, in IDLE:
  - If level>=2, the head address is even, and the next entry's address equals head+1, issue one word write with mem_din={next.d, head.d} and mem_be=2'b11.
  - On ack, pop both entries in that single cycle; a same-cycle push still counts.
  - Otherwise behave exactly as disabled.
- Disabled: one byte per request; the merge comparator is not synthesized.

Decomposition:
- Shared package dl_buf_pkg holds:
  - state enum {IDLE, WAIT};
  - entry struct {addr[AW-1:0], data[7:0]};
  - be localparams BE_LO=2'b01, BE_HI=2'b10, BE_W=2'b11.
- One sub-module, dl_fifo: a parameterised synchronous FIFO.
  - Exposes head and head+1 read ports, plus pop-count input 0/1/2 and level.
  - Top level holds the handshake FSM, lane mapping and flags.

Test Plan:
- Single byte: dl_wr addr=0x000005 data=0xA7 with ack 2 cycles after req → one request with mem_addr=0x000002, mem_din=0xA7A7, mem_be=2'b10. cpu_hold falls one cycle after ack with dl_active low.
- Burst of DEPTH+2 strobes on consecutive cycles with ack withheld → first DEPTH entries stored, overflow=1, level=DEPTH. Releasing acks drains exactly DEPTH requests in order. A dl_active rising edge clears overflow.
- Push and pop in the same cycle at level=DEPTH → byte accepted, level stays DEPTH, overflow stays 0.
- Reset_n pulsed low while in WAIT → mem_req=0 immediately (async), level=0. A later mem_ack is ignored and no write is issued.
- Merge enabled: bytes 0x11@0x000100 and 0x22@0x000101 queued → one request with mem_addr=0x000080, mem_din=0x2211, mem_be=2'b11, level 2→0. Merge disabled, same stimulus → two requests, be 01 then 10.
- Unaligned pair 0x33@0x000101 then 0x44@0x000102 with merge enabled → two separate byte requests, no merge.
